// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for the 16-bit, 4-register CPU datapath: steps each instruction
// through fetch/decode/execute/memory/write-back and counts retired instructions.
module multicycle_control #(
  parameter int unsigned CNT_W   = 16,
  parameter logic [3:0]  HALT_OP = 4'hF
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [3:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_source,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_START    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_WB_R     = 4'd8,
    S_WB_I     = 4'd9,
    S_WB_MEM   = 4'd10,
    S_BRANCH   = 4'd11,
    S_STOP     = 4'd12
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_LW   = 4'b0101;
  localparam logic [3:0] OP_SW   = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_BEQ  = 4'b1000;
  localparam logic [3:0] OP_BNE  = 4'b1001;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t           state_q;
  logic [CNT_W-1:0] count_q;
  logic             halted_q;
  logic             illegal_q;
  logic             retire_s;

  // Sequencer state, sticky stop flags and retired-instruction counter.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_START;
      count_q   <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      if (retire_s) begin
        count_q <= count_q + CNT_W'(1);
      end
      case (state_q)
        S_START:  state_q <= S_FETCH;
        S_FETCH:  if (mem_ready) state_q <= S_DECODE;
        S_DECODE: begin
          if (opcode == HALT_OP) begin
            state_q  <= S_STOP;
            halted_q <= 1'b1;
          end else begin
            case (opcode)
              OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: state_q <= S_EXEC_R;
              OP_ADDI:                               state_q <= S_EXEC_I;
              OP_LW, OP_SW:                          state_q <= S_MEM_ADDR;
              OP_BEQ, OP_BNE:                        state_q <= S_BRANCH;
              default: begin
                state_q   <= S_STOP;
                halted_q  <= 1'b1;
                illegal_q <= 1'b1;
              end
            endcase
          end
        end
        S_EXEC_R:   state_q <= S_WB_R;
        S_EXEC_I:   state_q <= S_WB_I;
        S_MEM_ADDR: state_q <= (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:   if (mem_ready) state_q <= S_WB_MEM;
        S_MEM_WR:   if (mem_ready) state_q <= S_FETCH;
        S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH: state_q <= S_FETCH;
        S_STOP:     state_q <= S_STOP;
        default:    state_q <= S_START;
      endcase
    end
  end

  // Datapath controls decoded from the current state (plus opcode/zero/mem_ready where needed).
  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_source  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 3'b000;
    retire_s   = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = ALU_ADD;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        alu_op    = ALU_ADD;
        retire_s  = (opcode == HALT_OP);
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        case (opcode)
          OP_ADD:  alu_op = ALU_ADD;
          OP_SUB:  alu_op = ALU_SUB;
          OP_AND:  alu_op = ALU_AND;
          OP_OR:   alu_op = ALU_OR;
          OP_SLT:  alu_op = ALU_SLT;
          default: alu_op = 3'b000;
        endcase
      end
      S_EXEC_I, S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      S_MEM_WR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        iord      = 1'b1;
        retire_s  = mem_ready;
      end
      S_WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire_s  = 1'b1;
      end
      S_WB_I: begin
        reg_write = 1'b1;
        retire_s  = 1'b1;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire_s   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_source = 1'b1;
        // beq takes the branch on equal operands, bne on unequal ones
        pc_write  = (opcode == OP_BNE) ? ~zero : zero;
        retire_s  = 1'b1;
      end
      default: begin
        retire_s = 1'b0;
      end
    endcase
  end

  assign halted      = halted_q;
  assign illegal     = illegal_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed scenarios plus a randomized instruction
// stream, each compared cycle by cycle against an instruction-level expectation model.
module tb_multicycle_control;
  localparam int CW = 10;
  localparam logic L0 = 1'b0;
  localparam logic L1 = 1'b1;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic [3:0]    opcode = 4'h0;
  logic          zero = 1'b0;
  logic          mem_ready = 1'b0;
  logic          mem_req, mem_write, iord, ir_write, pc_write, pc_source;
  logic          reg_write, reg_dst, mem_to_reg, alu_src_a, halted, illegal;
  logic [1:0]    alu_src_b;
  logic [2:0]    alu_op;
  logic [CW-1:0] instr_count;
  logic [16:0]   ctrl_vec;

  int            n_checks = 0;
  int            n_pass = 0;
  logic [CW-1:0] mcnt = '0;
  logic          stopped = 1'b0;
  logic [3:0]    legal_ops [10] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h7, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9};

  multicycle_control #(.CNT_W(CW), .HALT_OP(4'hF)) dut (
    .clock(clock), .resetn(resetn), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_source(pc_source), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .halted(halted), .illegal(illegal), .instr_count(instr_count)
  );

  assign ctrl_vec = {mem_req, mem_write, iord, ir_write, pc_write, pc_source, reg_write,
                     reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, halted, illegal};

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [16:0] mk(input logic req, input logic wr, input logic io,
      input logic irw, input logic pcw, input logic pcs, input logic rw, input logic rd,
      input logic m2r, input logic sa, input logic [1:0] sb, input logic [2:0] op,
      input logic h, input logic il);
    return {req, wr, io, irw, pcw, pcs, rw, rd, m2r, sa, sb, op, h, il};
  endfunction

  function automatic logic rnd1();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [3:0] rnd4();
    return 4'($urandom_range(0, 15));
  endfunction

  function automatic logic [2:0] r_alu(input logic [3:0] op);
    case (op)
      4'h0:    return 3'b010;
      4'h1:    return 3'b110;
      4'h2:    return 3'b000;
      4'h3:    return 3'b001;
      default: return 3'b111;
    endcase
  endfunction

  // one clock cycle: drive inputs, compare controls at the falling edge, advance past posedge
  task automatic cyc(input string tag, input logic [3:0] op, input logic z, input logic rdy,
                     input logic [16:0] exp);
    opcode = op; zero = z; mem_ready = rdy;
    @(negedge clock);
    check(tag, 32'(ctrl_vec), 32'(exp));
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    #1;
    check("rst_outs", 32'(ctrl_vec), 32'd0);
    check("rst_count", 32'(instr_count), 32'd0);
    mcnt = '0;
    stopped = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;
    #1;
    check("start_outs", 32'(ctrl_vec), 32'd0);
    @(posedge clock);
    #1;
  endtask

  // expected cycle sequence of one whole instruction, derived from its class
  task automatic run_instr(input logic [3:0] op, input int fw, input int mw, input logic z);
    logic il;
    for (int i = 0; i < fw; i++)
      cyc("fetch_wait", rnd4(), rnd1(), L0, mk(L1,L0,L0,L0,L0,L0,L0,L0,L0,L0,2'b01,3'b010,L0,L0));
    cyc("fetch", rnd4(), rnd1(), L1, mk(L1,L0,L0,L1,L1,L0,L0,L0,L0,L0,2'b01,3'b010,L0,L0));
    cyc("decode", op, rnd1(), rnd1(), mk(L0,L0,L0,L0,L0,L0,L0,L0,L0,L0,2'b11,3'b010,L0,L0));
    il = 1'b0;
    case (op)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h7: begin
        cyc("exec_r", op, rnd1(), rnd1(), mk(L0,L0,L0,L0,L0,L0,L0,L0,L0,L1,2'b00,r_alu(op),L0,L0));
        cyc("wb_r", op, rnd1(), rnd1(), mk(L0,L0,L0,L0,L0,L0,L1,L1,L0,L0,2'b00,3'b000,L0,L0));
        mcnt++;
      end
      4'h4: begin
        cyc("exec_i", op, rnd1(), rnd1(), mk(L0,L0,L0,L0,L0,L0,L0,L0,L0,L1,2'b10,3'b010,L0,L0));
        cyc("wb_i", op, rnd1(), rnd1(), mk(L0,L0,L0,L0,L0,L0,L1,L0,L0,L0,2'b00,3'b000,L0,L0));
        mcnt++;
      end
      4'h5, 4'h6: begin
        cyc("mem_addr", op, rnd1(), rnd1(), mk(L0,L0,L0,L0,L0,L0,L0,L0,L0,L1,2'b10,3'b010,L0,L0));
        for (int i = 0; i <= mw; i++)
          cyc("mem_acc", op, rnd1(), (i == mw),
              mk(L1,(op == 4'h6),L1,L0,L0,L0,L0,L0,L0,L0,2'b00,3'b000,L0,L0));
        if (op == 4'h5)
          cyc("wb_mem", op, rnd1(), rnd1(), mk(L0,L0,L0,L0,L0,L0,L1,L0,L1,L0,2'b00,3'b000,L0,L0));
        mcnt++;
      end
      4'h8, 4'h9: begin
        cyc("branch", op, z, rnd1(),
            mk(L0,L0,L0,L0,(op == 4'h8) ? z : ~z,L1,L0,L0,L0,L1,2'b00,3'b110,L0,L0));
        mcnt++;
      end
      4'hF: begin
        mcnt++;
        stopped = 1'b1;
      end
      default: begin
        il = 1'b1;
        stopped = 1'b1;
      end
    endcase
    check("count", 32'(instr_count), 32'(mcnt));
    if (stopped)
      repeat (3)
        cyc("stop", rnd4(), rnd1(), rnd1(), mk(L0,L0,L0,L0,L0,L0,L0,L0,L0,L0,2'b00,3'b000,L1,il));
  endtask

  initial begin
    do_reset();
    // straight-line add, then lw with three memory wait cycles
    run_instr(4'h0, 0, 0, L0);
    check("add_count", 32'(instr_count), 32'd1);
    run_instr(4'h5, 0, 3, L0);
    // both branch kinds with both flag values
    run_instr(4'h8, 0, 0, L1);
    run_instr(4'h8, 0, 0, L0);
    run_instr(4'h9, 0, 0, L1);
    run_instr(4'h9, 1, 0, L0);
    // illegal opcode must not count
    run_instr(4'hA, 0, 0, L0);
    check("illegal_cnt", 32'(instr_count), 32'd6);
    check("illegal_flag", 32'(illegal), 32'd1);
    do_reset();
    run_instr(4'h6, 2, 1, L0);
    run_instr(4'hF, 0, 0, L0);
    check("halt_cnt", 32'(instr_count), 32'd2);
    check("halt_illegal", 32'(illegal), 32'd0);
    // reset while a store is waiting on memory
    do_reset();
    cyc("fetch", rnd4(), L0, L1, mk(L1,L0,L0,L1,L1,L0,L0,L0,L0,L0,2'b01,3'b010,L0,L0));
    cyc("decode", 4'h6, L0, L0, mk(L0,L0,L0,L0,L0,L0,L0,L0,L0,L0,2'b11,3'b010,L0,L0));
    cyc("mem_addr", 4'h6, L0, L0, mk(L0,L0,L0,L0,L0,L0,L0,L0,L0,L1,2'b10,3'b010,L0,L0));
    mem_ready = 1'b0;
    @(negedge clock);
    check("mem_wr_hold", 32'(ctrl_vec), 32'(mk(L1,L1,L1,L0,L0,L0,L0,L0,L0,L0,2'b00,3'b000,L0,L0)));
    #2;
    do_reset();
    // randomized instruction stream
    for (int n = 0; n < 300; n++) begin
      logic [3:0] op;
      if ($urandom_range(0, 19) == 0) op = rnd4();
      else op = legal_ops[$urandom_range(0, 9)];
      run_instr(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), rnd1());
      if (stopped) do_reset();
    end
    // counter wrap-around
    do_reset();
    for (int n = 0; n < (2 ** CW) - 1; n++) run_instr(4'h4, 0, 0, rnd1());
    check("count_full", 32'(instr_count), 32'((2 ** CW) - 1));
    run_instr(4'h4, 0, 0, L0);
    check("count_wrap", 32'(instr_count), 32'd0);
    check("wrap_no_halt", 32'(halted), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
